pc_fetch_ctrl: RTL and testbench
================================

Name: pc_fetch_ctrl

Overview:
Sequencing controller for the 64-bit program counter in the pipelined RV64 core. Owns the PC register and selects the next PC from four sources: trap vector, branch/jump redirect, stall hold, or sequential +4. Drives the instruction-memory request handshake. Generates IF/ID flush pulses and a bubble window after every redirect.

Parameters:
XLEN, 64, PC / address width
RESET_VECTOR, 64'h0, PC value loaded on reset
FLUSH_CYCLES, 2, cycles flush_o stays high per redirect (min 1, max 7)
CNT_W, 32, width of the saturating redirect counter

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
stall_i  in  1  hazard-unit stall; holds PC
br_taken_i  in  1  EX-stage branch/jump redirect valid
br_target_i  in  XLEN  redirect target
trap_i  in  1  trap request from EX/MEM
trap_vector_i  in  XLEN  trap handler address, 4-byte aligned
imem_ready_i  in  1  imem accepted the current request this cycle
imem_req_o  out  1  instruction fetch request
pc_o  out  XLEN  current PC; also the fetch address
if_valid_o  out  1  one-cycle pulse: the fetch at the old pc_o completed
flush_o  out  1  squash IF/ID (and ID/EX) contents
misalign_o  out  1  one-cycle pulse: br_target_i[1:0] != 0
redirect_cnt_o  out  CNT_W  count of redirects taken, saturating

Behaviour:
- Reset (async, active-high; clock is clk):
  - pc_o=RESET_VECTOR; state=IDLE.
  - imem_req_o, if_valid_o, flush_o and misalign_o are 0; redirect_cnt_o=0; flush counter=0.
  - Reset mid-operation aborts any fetch or flush immediately.
- States: IDLE, FETCH, FLUSH. All outputs are registered except imem_req_o, which is decoded from state.
- IDLE:
  - imem_req_o=0.
  - Unconditionally goes to FETCH on the next edge, so the first request is in cycle 2 after rst deasserts.
- FETCH (imem_req_o=1), priority highest first:
  1. trap_i: pc<=trap_vector_i; go to FLUSH.
  2. br_taken_i with aligned target: pc<=br_target_i; go to FLUSH.
  3. br_taken_i with br_target_i[1:0]!=0: pc<=trap_vector_i; misalign_o=1 next cycle; go to FLUSH.
  4. stall_i: pc held; imem_req_o stays 1 and the address stays stable; if_valid_o=0.
  5. imem_ready_i: pc<=pc+4, with modulo-2^XLEN wrap (all-ones minus 3 wraps to 0); if_valid_o=1 next cycle.
  6. Otherwise pc is held (waiting on memory); if_valid_o=0.
- Redirect rules:
  - A redirect overrides stall_i and imem_ready_i in the same cycle; no if_valid_o pulse is generated.
  - redirect_cnt_o increments by 1 per taken redirect (cases 1-3, including redirects in FLUSH) and saturates at all-ones.
- FLUSH:
  - On entry, flush_o=1 and flush counter=FLUSH_CYCLES-1; imem_req_o=0 throughout.
  - Each cycle the counter decrements; flush_o is held while it is non-zero.
  - When the counter reaches 0, flush_o drops and the state returns to FETCH the same edge.
  - flush_o is high for exactly FLUSH_CYCLES cycles.
  - A new trap_i or br_taken_i in FLUSH reloads pc with the same priority and restarts the counter.
  - stall_i and imem_ready_i are ignored in FLUSH.
- Latency:
  - Redirect asserted in cycle N: pc_o holds the new target and flush_o=1 from cycle N+1.
  - The first request to the target is in cycle N+1+FLUSH_CYCLES.
- Simultaneous events: trap_i with br_taken_i resolves to trap; br_target_i is ignored and misalign_o is not raised.

Test Plan:
- Reset release, RESET_VECTOR=0, imem_ready_i=1 constant -> imem_req_o rises cycle 2; pc_o steps 0,4,8,C, with if_valid_o pulses on each step.
- stall_i high 3 cycles at pc=0x10, imem_ready_i=1 -> pc_o holds 0x10 for 3 cycles, imem_req_o stays 1, no if_valid_o; then advances to 0x14.
- br_taken_i, target 0x200, at pc=0x20 with stall_i=1 -> pc_o=0x200 next cycle; flush_o high exactly 2 cycles; imem_req_o low 2 cycles; redirect_cnt_o=1.
- trap_i plus br_taken_i same cycle, trap_vector_i=0x80, target 0x400 -> pc_o=0x80; misalign_o stays 0.
- br_target_i=0x302 -> pc_o=trap_vector_i, misalign_o single pulse; second branch to 0x500 during FLUSH -> pc_o=0x500, flush window restarts at 2 cycles, redirect_cnt_o=2.
- pc=64'hFFFF_FFFF_FFFF_FFFC, imem_ready_i=1 -> pc_o wraps to 0. Assert rst mid-FLUSH -> all outputs return to reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/pc_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pc_fetch_ctrl
// Purpose  : Owns the fetch PC, drives the imem request handshake and opens a
//            flush window after every trap or branch redirect.
// Revision : 1.0 - initial release
// ============================================================================
module pc_fetch_ctrl #(
  parameter int              XLEN         = 64,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int              FLUSH_CYCLES = 2,
  parameter int              CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall_i,
  input  logic             br_taken_i,
  input  logic [XLEN-1:0]  br_target_i,
  input  logic             trap_i,
  input  logic [XLEN-1:0]  trap_vector_i,
  input  logic             imem_ready_i,
  output logic             imem_req_o,
  output logic [XLEN-1:0]  pc_o,
  output logic             if_valid_o,
  output logic             flush_o,
  output logic             misalign_o,
  output logic [CNT_W-1:0] redirect_cnt_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_FLUSH = 2'd2
  } state_t;

  localparam logic [2:0]       c_FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);
  localparam logic [XLEN-1:0]  c_PC_STEP    = XLEN'(4);
  localparam logic [CNT_W-1:0] c_CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] c_CNT_MAX    = '1;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [XLEN-1:0]  r_pc;
  logic [XLEN-1:0]  w_pc_nxt;
  logic             r_flush;
  logic             w_flush_nxt;
  logic [2:0]       r_flush_cnt;
  logic [2:0]       w_flush_cnt_nxt;
  logic             r_if_valid;
  logic             w_if_valid_nxt;
  logic             r_misalign;
  logic             w_misalign_nxt;
  logic [CNT_W-1:0] r_redirect_cnt;
  logic [CNT_W-1:0] w_redirect_cnt_nxt;

  logic             w_redirect;
  logic             w_tgt_misaligned;
  logic [XLEN-1:0]  w_redirect_pc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= S_IDLE;
      r_pc           <= RESET_VECTOR;
      r_flush        <= 1'b0;
      r_flush_cnt    <= 3'd0;
      r_if_valid     <= 1'b0;
      r_misalign     <= 1'b0;
      r_redirect_cnt <= '0;
    end else begin
      r_state        <= w_state_nxt;
      r_pc           <= w_pc_nxt;
      r_flush        <= w_flush_nxt;
      r_flush_cnt    <= w_flush_cnt_nxt;
      r_if_valid     <= w_if_valid_nxt;
      r_misalign     <= w_misalign_nxt;
      r_redirect_cnt <= w_redirect_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt        = r_state;
    w_pc_nxt           = r_pc;
    w_flush_nxt        = 1'b0;
    w_flush_cnt_nxt    = r_flush_cnt;
    w_if_valid_nxt     = 1'b0;
    w_misalign_nxt     = 1'b0;
    w_redirect_cnt_nxt = r_redirect_cnt;

    // A trap masks the branch entirely, so its alignment never matters then.
    w_tgt_misaligned = (br_target_i[1:0] != 2'b00);
    w_redirect_pc    = (trap_i || w_tgt_misaligned) ? trap_vector_i : br_target_i;
    w_redirect       = ((r_state == S_FETCH) || (r_state == S_FLUSH)) &&
                       (trap_i || br_taken_i);

    if (w_redirect) begin
      w_state_nxt     = S_FLUSH;
      w_pc_nxt        = w_redirect_pc;
      w_flush_nxt     = 1'b1;
      w_flush_cnt_nxt = c_FLUSH_LOAD;
      w_misalign_nxt  = !trap_i && w_tgt_misaligned;
      if (r_redirect_cnt != c_CNT_MAX) begin
        w_redirect_cnt_nxt = r_redirect_cnt + c_CNT_ONE;
      end
    end else begin
      case (r_state)
        S_IDLE: begin
          w_state_nxt = S_FETCH;
        end
        S_FETCH: begin
          if (!stall_i && imem_ready_i) begin
            w_pc_nxt       = r_pc + c_PC_STEP;
            w_if_valid_nxt = 1'b1;
          end
        end
        S_FLUSH: begin
          if (r_flush_cnt == 3'd0) begin
            w_state_nxt = S_FETCH;
          end else begin
            w_flush_cnt_nxt = r_flush_cnt - 3'd1;
            w_flush_nxt     = 1'b1;
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
        end
      endcase
    end

    imem_req_o = (r_state == S_FETCH);
  end

  assign pc_o           = r_pc;
  assign if_valid_o     = r_if_valid;
  assign flush_o        = r_flush;
  assign misalign_o     = r_misalign;
  assign redirect_cnt_o = r_redirect_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pc_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pc_fetch_ctrl
// Purpose  : Directed stimulus with queued expectations for pc_fetch_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pc_fetch_ctrl;

  logic        clk;
  logic        rst;
  logic        stall_i;
  logic        br_taken_i;
  logic [63:0] br_target_i;
  logic        trap_i;
  logic [63:0] trap_vector_i;
  logic        imem_ready_i;
  logic        imem_req_o;
  logic [63:0] pc_o;
  logic        if_valid_o;
  logic        flush_o;
  logic        misalign_o;
  logic [31:0] redirect_cnt_o;

  pc_fetch_ctrl #(
    .XLEN(64), .RESET_VECTOR(64'h0), .FLUSH_CYCLES(2), .CNT_W(32)
  ) dut (
    .clk(clk), .rst(rst), .stall_i(stall_i), .br_taken_i(br_taken_i),
    .br_target_i(br_target_i), .trap_i(trap_i), .trap_vector_i(trap_vector_i),
    .imem_ready_i(imem_ready_i), .imem_req_o(imem_req_o), .pc_o(pc_o),
    .if_valid_o(if_valid_o), .flush_o(flush_o), .misalign_o(misalign_o),
    .redirect_cnt_o(redirect_cnt_o)
  );

  typedef struct {
    logic [63:0] pc;
    logic        mis;
    logic [31:0] cnt;
  } flush_exp_t;

  logic [63:0] fetch_q[$];
  flush_exp_t  flush_q[$];
  int          n_checks = 0;
  int          n_pass   = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_flush(input logic [63:0] pc, input logic mis, input logic [31:0] cnt);
    flush_exp_t e;
    e.pc = pc; e.mis = mis; e.cnt = cnt;
    flush_q.push_back(e);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_pc"},    pc_o,           64'h0);
    chk({tag, "_req"},   imem_req_o,     64'h0);
    chk({tag, "_ifv"},   if_valid_o,     64'h0);
    chk({tag, "_flush"}, flush_o,        64'h0);
    chk({tag, "_mis"},   misalign_o,     64'h0);
    chk({tag, "_cnt"},   redirect_cnt_o, 64'h0);
  endtask

  // Monitor: every completed fetch or flush cycle consumes one expectation.
  initial begin
    logic [63:0] fe;
    flush_exp_t  xe;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (if_valid_o) begin
          if (fetch_q.size() == 0) begin
            n_checks++;
            $display("FAIL fetch_extra: if_valid_o at pc_o=%h, expected no pulse", pc_o);
          end else begin
            fe = fetch_q.pop_front();
            chk("fetch_pc", pc_o, fe);
            chk("fetch_req", imem_req_o, 64'h1);
          end
        end
        if (flush_o) begin
          if (flush_q.size() == 0) begin
            n_checks++;
            $display("FAIL flush_extra: flush_o at pc_o=%h, expected low", pc_o);
          end else begin
            xe = flush_q.pop_front();
            chk("flush_pc", pc_o, xe.pc);
            chk("flush_req", imem_req_o, 64'h0);
            chk("flush_mis", misalign_o, {63'h0, xe.mis});
            chk("flush_cnt", redirect_cnt_o, {32'h0, xe.cnt});
          end
        end else if (misalign_o) begin
          n_checks++;
          $display("FAIL mis_stray: misalign_o=1 outside flush, expected 0");
        end
      end
    end
  end

  initial begin
    rst = 1'b1; stall_i = 1'b0; br_taken_i = 1'b0; br_target_i = '0;
    trap_i = 1'b0; trap_vector_i = '0; imem_ready_i = 1'b1;
    tick(); tick();
    check_reset_values("rst");

    rst = 1'b0;
    #1 chk("idle_req", imem_req_o, 64'h0);
    tick();
    chk("first_req", imem_req_o, 64'h1);
    chk("first_pc", pc_o, 64'h0);

    foreach (fetch_q[i]) ;
    fetch_q.push_back(64'h4); fetch_q.push_back(64'h8);
    fetch_q.push_back(64'hC); fetch_q.push_back(64'h10);
    repeat (4) tick();

    stall_i = 1'b1;
    repeat (3) begin
      tick();
      chk("stall_pc", pc_o, 64'h10);
      chk("stall_req", imem_req_o, 64'h1);
    end
    stall_i = 1'b0;
    fetch_q.push_back(64'h14); fetch_q.push_back(64'h18);
    fetch_q.push_back(64'h1C); fetch_q.push_back(64'h20);
    repeat (4) tick();

    // Branch overrides a concurrent stall.
    br_taken_i = 1'b1; br_target_i = 64'h200; stall_i = 1'b1;
    push_flush(64'h200, 1'b0, 32'd1); push_flush(64'h200, 1'b0, 32'd1);
    fetch_q.push_back(64'h204);
    tick();
    br_taken_i = 1'b0; stall_i = 1'b0;
    repeat (3) tick();

    trap_i = 1'b1; trap_vector_i = 64'h80; br_taken_i = 1'b1; br_target_i = 64'h400;
    push_flush(64'h80, 1'b0, 32'd2); push_flush(64'h80, 1'b0, 32'd2);
    fetch_q.push_back(64'h84);
    tick();
    trap_i = 1'b0; br_taken_i = 1'b0;
    repeat (3) tick();

    // Misaligned target, then a second branch restarting the flush window.
    br_taken_i = 1'b1; br_target_i = 64'h302;
    push_flush(64'h80, 1'b1, 32'd3);
    tick();
    br_target_i = 64'h500;
    push_flush(64'h500, 1'b0, 32'd4); push_flush(64'h500, 1'b0, 32'd4);
    fetch_q.push_back(64'h504);
    tick();
    br_taken_i = 1'b0;
    repeat (3) tick();

    br_taken_i = 1'b1; br_target_i = 64'hFFFF_FFFF_FFFF_FFFC;
    push_flush(64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 32'd5);
    push_flush(64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 32'd5);
    fetch_q.push_back(64'h0); fetch_q.push_back(64'h4); fetch_q.push_back(64'h8);
    tick();
    br_taken_i = 1'b0;
    repeat (5) tick();

    trap_i = 1'b1; trap_vector_i = 64'h80;
    push_flush(64'h80, 1'b0, 32'd6);
    tick();
    trap_i = 1'b0;
    #6 rst = 1'b1;
    #1 check_reset_values("async_rst");
    repeat (3) tick();

    chk("fetch_q_empty", 64'(fetch_q.size()), 64'h0);
    chk("flush_q_empty", 64'(flush_q.size()), 64'h0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
